// File: rtl/interval_timer_pkg.sv
// Shared types and constants for the interval timer.
// Channel FSM states and the default system clock frequency.
package interval_timer_pkg;

  localparam int CLK_FREQ = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/interval_timer_if.sv
// Control/status bundle between the timer and its user.
// Channel i of every vector lives at bit i (or [i*CNT_W +: CNT_W]).
interface interval_timer_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4
);
  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       stop;
  logic [N_CH-1:0]       reload;
  logic [N_CH-1:0]       dir;
  logic [N_CH*CNT_W-1:0] interval;
  logic                  tick;
  logic [N_CH*CNT_W-1:0] count;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       timeout;
  logic [N_CH-1:0]       expired;

  modport master (
    output start, stop, reload, dir, interval,
    input  tick, count, busy, timeout, expired
  );

  modport slave (
    input  start, stop, reload, dir, interval,
    output tick, count, busy, timeout, expired
  );
endinterface

// File: rtl/interval_timer_tick_prescaler.sv
// Free-running divider producing a registered 1-cycle tick every TICK_DIV clocks.
// TICK_DIV=1 keeps the divider at 0 so the tick is high every cycle.
module tick_prescaler
  import interval_timer_pkg::*;
#(
  parameter int TICK_DIV = CLK_FREQ
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] r_div;
  logic          r_tick;
  logic          w_wrap;

  assign w_wrap = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      r_div  <= w_wrap ? '0 : r_div + DW'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/interval_timer.sv
// Multi-channel interval timer: one shared prescaler, N_CH independent
// up/down channels with one-shot or auto-reload behaviour.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 4,
  parameter int TICK_DIV = CLK_FREQ
) (
  input  logic             clk,
  input  logic             rst,
  interval_timer_if.slave  bus
);

  logic w_tick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign bus.tick = w_tick;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ch_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_ival, w_ival_in;
    logic             r_ldir, r_lrel, r_exp, w_exp_nxt, r_to, w_to_nxt;
    logic             w_term, w_load;

    assign w_ival_in = bus.interval[g*CNT_W +: CNT_W];
    assign w_load    = bus.start[g] && !bus.stop[g];
    assign w_term    = r_ldir ? (r_cnt == r_ival) : (r_cnt == '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_ival  <= '0;
        r_ldir  <= 1'b0;
        r_lrel  <= 1'b0;
        r_exp   <= 1'b0;
        r_to    <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_exp   <= w_exp_nxt;
        r_to    <= w_to_nxt;
        if (w_load) begin
          r_ival <= w_ival_in;
          r_ldir <= bus.dir[g];
          r_lrel <= bus.reload[g];
        end
      end
    end

    // stop beats start beats tick; a start swallows a coincident tick
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_exp_nxt   = r_exp;
      w_to_nxt    = 1'b0;
      if (bus.stop[g]) begin
        w_state_nxt = ST_IDLE;
        w_exp_nxt   = 1'b0;
      end else if (bus.start[g]) begin
        w_state_nxt = ST_RUN;
        w_exp_nxt   = 1'b0;
        w_cnt_nxt   = bus.dir[g] ? '0 : w_ival_in;
      end else if (r_state == ST_RUN && w_tick) begin
        if (w_term) begin
          w_to_nxt = 1'b1;
          if (r_lrel) begin
            w_cnt_nxt = r_ldir ? '0 : r_ival;
          end else begin
            w_state_nxt = ST_DONE;
            w_exp_nxt   = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_ldir ? r_cnt + CNT_W'(1) : r_cnt - CNT_W'(1);
        end
      end
    end

    assign bus.count[g*CNT_W +: CNT_W] = r_cnt;
    assign bus.busy[g]    = (r_state == ST_RUN);
    assign bus.timeout[g] = r_to;
    assign bus.expired[g] = r_exp;
  end

endmodule

// File: tb/tb_interval_timer.sv
// Randomized scoreboard bench: two timers (TICK_DIV=4 and TICK_DIV=1) share
// stimulus; a tick-counting reference model predicts every cycle's outputs.
module tb_interval_timer;
  localparam int N_CH  = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic                  tick;
    logic [N_CH*CNT_W-1:0] count;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       timeout;
    logic [N_CH-1:0]       expired;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_CH-1:0]       start, stop, reload, dir;
  logic [N_CH*CNT_W-1:0] interval;

  interval_timer_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus0 ();
  interval_timer_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus1 ();

  interval_timer #(.N_CH(N_CH), .CNT_W(CNT_W), .TICK_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  interval_timer #(.N_CH(N_CH), .CNT_W(CNT_W), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  assign bus0.start = start;   assign bus1.start = start;
  assign bus0.stop = stop;     assign bus1.stop = stop;
  assign bus0.reload = reload; assign bus1.reload = reload;
  assign bus0.dir = dir;       assign bus1.dir = dir;
  assign bus0.interval = interval; assign bus1.interval = interval;

  // Reference model: elapsed ticks since (re)start, per channel, per DUT
  int  k [2];
  bit  mt [2];
  bit  run [2][N_CH], ex [2][N_CH], ld [2][N_CH], lr [2][N_CH];
  int  el [2][N_CH], iv [2][N_CH], cnt [2][N_CH];

  snap_t q0[$], q1[$];
  bit    armed = 1'b0;
  int    checks = 0, passes = 0;

  task automatic step(input int u, output snap_t s);
    s = '0;
    if (rst) begin
      k[u] = 0; mt[u] = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        run[u][c] = 0; ex[u][c] = 0; el[u][c] = 0; cnt[u][c] = 0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (stop[c]) begin
          run[u][c] = 0; ex[u][c] = 0;
        end else if (start[c]) begin
          iv[u][c] = int'(interval[c*CNT_W +: CNT_W]);
          ld[u][c] = dir[c]; lr[u][c] = reload[c];
          el[u][c] = 0; run[u][c] = 1; ex[u][c] = 0;
          cnt[u][c] = ld[u][c] ? 0 : iv[u][c];
        end else if (run[u][c] && mt[u]) begin
          if (el[u][c] == iv[u][c]) begin
            s.timeout[c] = 1'b1;
            if (lr[u][c]) el[u][c] = 0;
            else begin run[u][c] = 0; ex[u][c] = 1; end
          end else el[u][c]++;
          cnt[u][c] = ld[u][c] ? el[u][c] : iv[u][c] - el[u][c];
        end
      end
      k[u]++;
      mt[u] = ((k[u] % (u == 0 ? 4 : 1)) == 0);
    end
    s.tick = mt[u];
    for (int c = 0; c < N_CH; c++) begin
      s.count[c*CNT_W +: CNT_W] = CNT_W'(cnt[u][c]);
      s.busy[c]    = run[u][c];
      s.expired[c] = ex[u][c];
    end
  endtask

  // Inputs for the next edge are already set; predict and enqueue, then advance
  task automatic commit();
    snap_t s;
    step(0, s); q0.push_back(s);
    step(1, s); q1.push_back(s);
    armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic check(input string nm, input bit empty, input snap_t a, input snap_t e);
    checks++;
    if (empty)
      $display("FAIL %s t=%0t no expected entry queued", nm, $time);
    else if (a !== e)
      $display("FAIL %s t=%0t got tick=%b cnt=%h busy=%b to=%b exp=%b want tick=%b cnt=%h busy=%b to=%b exp=%b",
               nm, $time, a.tick, a.count, a.busy, a.timeout, a.expired,
               e.tick, e.count, e.busy, e.timeout, e.expired);
    else passes++;
  endtask

  snap_t ma, me;
  bit    mem;
  always @(posedge clk) begin
    #1;
    if (armed) begin
      ma = {bus0.tick, bus0.count, bus0.busy, bus0.timeout, bus0.expired};
      mem = (q0.size() == 0);
      me = mem ? '0 : q0.pop_front();
      check("dut0_div4", mem, ma, me);
      ma = {bus1.tick, bus1.count, bus1.busy, bus1.timeout, bus1.expired};
      mem = (q1.size() == 0);
      me = mem ? '0 : q1.pop_front();
      check("dut1_div1", mem, ma, me);
    end
  end

  initial begin
    start = '0; stop = '0; reload = '0; dir = '0; interval = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) commit();
    rst = 1'b0;
    repeat (6) commit();

    // all channels at once, intervals 0..3, one-shot up
    start = '1; dir = '1; reload = '0;
    interval = {4'd3, 4'd2, 4'd1, 4'd0};
    commit();
    start = '0;
    repeat (24) commit();

    // ch1 auto-reload down from 2; inputs wiggle afterwards without effect
    start = 4'b0010; dir = '0; reload = 4'b0010;
    interval = '0; interval[CNT_W +: CNT_W] = 4'd2;
    commit();
    start = '0; dir = '1; reload = '0; interval = '1;
    repeat (30) commit();

    // ch0 up to 15, then stop/start collisions
    start = 4'b0001; dir = 4'b0001; reload = '0; interval = '1;
    commit();
    start = '0;
    repeat (70) commit();
    start = 4'b0001; stop = 4'b0001; commit();
    start = '0; stop = '0; repeat (5) commit();

    for (int n = 0; n < 2500; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        start[c]  = ($urandom % 40) == 0;
        stop[c]   = ($urandom % 90) == 0;
        dir[c]    = $urandom % 2;
        reload[c] = $urandom % 2;
        if (($urandom % 4) == 0)
          interval[c*CNT_W +: CNT_W] = ($urandom % 2) ? '1 : '0;
        else
          interval[c*CNT_W +: CNT_W] = CNT_W'($urandom);
      end
      if (n == 1200) rst = 1'b1;
      if (n == 1203) rst = 1'b0;
      commit();
    end
    start = '0; stop = '0;
    repeat (2) commit();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
